// File: rtl/zigzag_rle.sv
// zigzag_rle: scans a quantized 8x8 coefficient block in JPEG zigzag order and emits
// (zero-run, value) symbols with valid/ready flow control. DC is always emitted first;
// trailing zeros collapse into a single EOB symbol.
module zigzag_rle #(
  parameter int unsigned BLOCK_SIZE  = 8,   // only 8 is supported; the zigzag table is fixed 8x8
  parameter int unsigned COEFF_WIDTH = 9,
  parameter int unsigned RUN_WIDTH   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [COEFF_WIDTH-1:0] coeffs_in [BLOCK_SIZE][BLOCK_SIZE],
  input  logic                          block_valid,
  output logic                          block_ready,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic [RUN_WIDTH-1:0]          sym_run,
  output logic signed [COEFF_WIDTH-1:0] sym_value,
  output logic                          sym_dc,
  output logic                          sym_eob,
  output logic                          sym_last
);

  localparam int unsigned NUM_COEFFS = BLOCK_SIZE * BLOCK_SIZE;
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_COEFFS);
  localparam int unsigned POS_WIDTH  = $clog2(BLOCK_SIZE);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COEFFS - 1);

  // Zigzag scan position -> linear index (row*8 + col).
  localparam logic [5:0] ZZ_LUT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_EOB  = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [IDX_WIDTH-1:0]            idx_q, idx_d;
  logic [RUN_WIDTH-1:0]            run_q, run_d;
  logic signed [COEFF_WIDTH-1:0]   blk_q [NUM_COEFFS];
  logic signed [COEFF_WIDTH-1:0]   blk_d [NUM_COEFFS];
  logic                            block_ready_q, block_ready_d;
  logic                            sym_valid_q, sym_valid_d;
  logic [RUN_WIDTH-1:0]            sym_run_q, sym_run_d;
  logic signed [COEFF_WIDTH-1:0]   sym_value_q, sym_value_d;
  logic                            sym_dc_q, sym_dc_d;
  logic                            sym_eob_q, sym_eob_d;
  logic                            sym_last_q, sym_last_d;
  logic signed [COEFF_WIDTH-1:0]   cur_coeff;

  assign cur_coeff = blk_q[ZZ_LUT[idx_q]];

  // Next-state, scan counters, block capture and symbol output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_d       = run_q;
    blk_d       = blk_q;
    sym_valid_d = sym_valid_q;
    sym_run_d   = sym_run_q;
    sym_value_d = sym_value_q;
    sym_dc_d    = sym_dc_q;
    sym_eob_d   = sym_eob_q;
    sym_last_d  = sym_last_q;

    case (state_q)
      ST_IDLE: begin
        if (block_valid && block_ready_q) begin
          for (int unsigned r = 0; r < BLOCK_SIZE; r++) begin
            for (int unsigned c = 0; c < BLOCK_SIZE; c++) begin
              blk_d[IDX_WIDTH'(r * BLOCK_SIZE + c)] = coeffs_in[POS_WIDTH'(r)][POS_WIDTH'(c)];
            end
          end
          idx_d   = '0;
          run_d   = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if ((idx_q == '0) || (cur_coeff != '0)) begin
          sym_valid_d = 1'b1;
          sym_run_d   = run_q;
          sym_value_d = cur_coeff;
          sym_dc_d    = (idx_q == '0);
          sym_eob_d   = 1'b0;
          sym_last_d  = (idx_q == LAST_IDX);
          state_d     = ST_EMIT;
        end else if (idx_q != LAST_IDX) begin
          run_d = run_q + RUN_WIDTH'(1);
          idx_d = idx_q + IDX_WIDTH'(1);
        end else begin
          sym_valid_d = 1'b1;
          sym_run_d   = '0;
          sym_value_d = '0;
          sym_dc_d    = 1'b0;
          sym_eob_d   = 1'b1;
          sym_last_d  = 1'b1;
          state_d     = ST_EOB;
        end
      end

      ST_EMIT: begin
        if (sym_ready) begin
          sym_valid_d = 1'b0;
          sym_run_d   = '0;
          sym_value_d = '0;
          sym_dc_d    = 1'b0;
          sym_eob_d   = 1'b0;
          sym_last_d  = 1'b0;
          if (sym_last_q) begin
            state_d = ST_IDLE;
          end else begin
            run_d   = '0;
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = ST_SCAN;
          end
        end
      end

      ST_EOB: begin
        if (sym_ready) begin
          sym_valid_d = 1'b0;
          sym_run_d   = '0;
          sym_value_d = '0;
          sym_dc_d    = 1'b0;
          sym_eob_d   = 1'b0;
          sym_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Input is only sampled while idle, so a block can never be re-captured mid-scan.
    block_ready_d = (state_d == ST_IDLE);
  end

  // State, counters, block register and registered outputs; reset discards any in-flight block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      run_q         <= '0;
      blk_q         <= '{default: '0};
      block_ready_q <= 1'b1;
      sym_valid_q   <= 1'b0;
      sym_run_q     <= '0;
      sym_value_q   <= '0;
      sym_dc_q      <= 1'b0;
      sym_eob_q     <= 1'b0;
      sym_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      run_q         <= run_d;
      blk_q         <= blk_d;
      block_ready_q <= block_ready_d;
      sym_valid_q   <= sym_valid_d;
      sym_run_q     <= sym_run_d;
      sym_value_q   <= sym_value_d;
      sym_dc_q      <= sym_dc_d;
      sym_eob_q     <= sym_eob_d;
      sym_last_q    <= sym_last_d;
    end
  end

  assign block_ready = block_ready_q;
  assign sym_valid   = sym_valid_q;
  assign sym_run     = sym_run_q;
  assign sym_value   = sym_value_q;
  assign sym_dc      = sym_dc_q;
  assign sym_eob     = sym_eob_q;
  assign sym_last    = sym_last_q;

endmodule
